// File: rtl/barrel_pkg.sv
// Shared types and constants for the barrel shift sequencer and its shifter.
package barrel_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic               dir;
    logic [SHAMT_W-1:0] shamt;
  } shift_cmd_t;

  function automatic logic [DATA_W-1:0] bit_reverse(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
    return r;
  endfunction

endpackage

// File: rtl/Right_barrel.sv
// Combinational 32-bit logical barrel shifter, zero fill; direction 1 = right.
import barrel_pkg::*;

module Right_barrel (
  input  logic [DATA_W-1:0]  data,
  input  logic               direction,
  input  logic [SHAMT_W-1:0] shift,
  output logic [DATA_W-1:0]  result
);

  // Left shifts reuse the right-shift core by mirroring the word around it.
  logic [DATA_W-1:0] pre;
  logic [DATA_W-1:0] shifted;

  assign pre     = (direction == DIR_RIGHT) ? data : bit_reverse(data);
  assign shifted = pre >> shift;
  assign result  = (direction == DIR_RIGHT) ? shifted : bit_reverse(shifted);

endmodule

// File: rtl/shift_cmd_fifo.sv
// Synchronous FIFO of shift commands; head is the entry at the read pointer.
import barrel_pkg::*;

module shift_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  shift_cmd_t               push_cmd,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output shift_cmd_t               head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  shift_cmd_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);
  assign head  = mem[rd_ptr];

  // Storage is left unreset; out_valid gating keeps stale entries invisible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_cmd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      level <= level + LVL_W'(1);
      else if (pop && !push) level <= level - LVL_W'(1);
    end
  end

endmodule

// File: rtl/barrel_shift_sequencer.sv
// Command FIFO + Right_barrel + registered result stage with valid/ready on both sides.
import barrel_pkg::*;

module barrel_shift_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_dir,
  input  logic [SHAMT_W-1:0]       in_shift,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         result_cnt
);

  shift_cmd_t        push_cmd;
  shift_cmd_t        head;
  logic              full;
  logic              empty;
  logic              push;
  logic              load;
  logic              deliver;
  logic [DATA_W-1:0] shifted;

  assign push_cmd = '{data: in_data, dir: in_dir, shamt: in_shift};
  // in_ready comes only from registered level: no pass-through when full.
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign deliver  = out_valid && out_ready;
  assign load     = !empty && (!out_valid || out_ready);

  shift_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_cmd (push_cmd),
    .pop      (load),
    .full     (full),
    .empty    (empty),
    .level    (fifo_level),
    .head     (head)
  );

  Right_barrel u_shifter (
    .data      (head.data),
    .direction (head.dir),
    .shift     (head.shamt),
    .result    (shifted)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      result_cnt <= '0;
    end else begin
      if (load) begin
        out_data  <= shifted;
        out_valid <= 1'b1;
      end else if (deliver) begin
        out_valid <= 1'b0;
      end
      if (deliver) result_cnt <= result_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_barrel_shift_sequencer.sv
// Self-checking bench: directed test-plan cases plus random traffic against a queue model.
module tb_barrel_shift_sequencer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready, in_ready4;
  logic [31:0] in_data = '0;
  logic        in_dir = 1'b0;
  logic [4:0]  in_shift = '0;
  logic        out_valid, out_valid4;
  logic        out_ready = 1'b0;
  logic [31:0] out_data, out_data4;
  logic [2:0]  fifo_level, fifo_level4;
  logic [15:0] result_cnt;
  logic [3:0]  result_cnt4;

  always #5 clk = ~clk;

  barrel_shift_sequencer #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dir(in_dir), .in_shift(in_shift),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fifo_level(fifo_level), .result_cnt(result_cnt)
  );

  barrel_shift_sequencer #(.DEPTH(DEPTH), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_dir(in_dir), .in_shift(in_shift),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .fifo_level(fifo_level4), .result_cnt(result_cnt4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: pending commands as a queue, one held result.
  typedef struct { logic [31:0] d; logic dir; int sh; } cmd_t;
  cmd_t        q[$];
  logic        m_valid;
  logic [31:0] m_data;
  int          m_cnt;
  int          accepted;

  function automatic logic [31:0] ref_shift(input cmd_t c);
    return c.dir ? (c.d >> c.sh) : (c.d << c.sh);
  endfunction

  task automatic check_all();
    check_eq("out_valid", 32'(out_valid), 32'(m_valid));
    check_eq("out_data", out_data, m_data);
    check_eq("fifo_level", 32'(fifo_level), 32'(q.size()));
    check_eq("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    check_eq("result_cnt", 32'(result_cnt), 32'(m_cnt % 65536));
    check_eq("result_cnt4", 32'(result_cnt4), 32'(m_cnt % 16));
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic dir,
                      input logic [4:0] sh, input logic ordy);
    cmd_t c;
    bit   fire_in, fire_out, ld;
    in_valid  = v; in_data = d; in_dir = dir; in_shift = sh; out_ready = ordy;
    c.d = d; c.dir = dir; c.sh = int'(sh);
    if (v && in_ready) accepted++;
    @(posedge clk);
    fire_in  = v && (q.size() < DEPTH);
    fire_out = m_valid && ordy;
    ld       = (q.size() > 0) && (!m_valid || ordy);
    if (fire_out) m_cnt++;
    if (ld) begin
      m_data  = ref_shift(q.pop_front());
      m_valid = 1'b1;
    end else if (fire_out) begin
      m_valid = 1'b0;
    end
    if (fire_in) q.push_back(c);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    q.delete(); m_valid = 1'b0; m_data = '0; m_cnt = 0;
    #1;
    rst = 1'b0;
    check_all();
  endtask

  localparam logic [31:0] D = 32'hD36093AD;

  initial begin
    #1;
    do_reset();
    check_eq("reset_out_data", out_data, 32'h0);

    // Right shift: valid two edges after acceptance.
    step(1'b1, D, 1'b1, 5'd16, 1'b1);
    check_eq("lat_edge1_valid", 32'(out_valid), 32'h0);
    step(1'b0, 32'h0, 1'b0, 5'd0, 1'b0);
    check_eq("right16_valid", 32'(out_valid), 32'h1);
    check_eq("right16_data", out_data, 32'h0000D360);
    step(1'b0, 32'h0, 1'b0, 5'd0, 1'b1);
    check_eq("right16_cnt", 32'(result_cnt), 32'h1);

    step(1'b1, D, 1'b0, 5'd16, 1'b1);
    step(1'b1, D, 1'b0, 5'd0, 1'b1);
    check_eq("left16_data", out_data, 32'h93AD0000);
    step(1'b0, 32'h0, 1'b0, 5'd0, 1'b1);
    check_eq("pass_data", out_data, 32'hD36093AD);
    step(1'b0, 32'h0, 1'b0, 5'd0, 1'b1);

    // Back-to-back streaming.
    step(1'b1, D, 1'b1, 5'd4, 1'b1);
    step(1'b1, D, 1'b0, 5'd4, 1'b1);
    check_eq("b2b_first", out_data, 32'h0D36093A);
    check_eq("b2b_level", 32'(fifo_level <= 3'd1), 32'h1);
    step(1'b0, 32'h0, 1'b0, 5'd0, 1'b1);
    check_eq("b2b_second", out_data, 32'h36093AD0);
    check_eq("b2b_second_valid", 32'(out_valid), 32'h1);
    step(1'b0, 32'h0, 1'b0, 5'd0, 1'b1);
    check_eq("drain_valid", 32'(out_valid), 32'h0);

    // Backpressure: 6 offered, 5 absorbed.
    do_reset();
    accepted = 0;
    for (int i = 0; i < 6; i++) step(1'b1, D, 1'b1, 5'(i + 1), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, D, 1'b1, 5'd9, 1'b0);
    check_eq("bp_accepted", 32'(accepted), 32'd5);
    check_eq("bp_in_ready", 32'(in_ready), 32'h0);
    check_eq("bp_held", out_data, D >> 1);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0, 5'd0, 1'b1);
    check_eq("bp_cnt", 32'(result_cnt), 32'd5);

    // Reset mid-operation: one held result, 3 buffered.
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 32'h1111_0001), 1'b0, 5'(i), 1'b0);
    check_eq("mid_level", 32'(fifo_level), 32'd3);
    do_reset();
    check_eq("mid_in_ready", 32'(in_ready), 32'h1);
    check_eq("mid_out_data", out_data, 32'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 5'd0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 99) < 60), $urandom, 1'($urandom),
           5'($urandom), 1'($urandom_range(0, 99) < 55));
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0, 5'd0, 1'b1);

    // Counter wrap on the 4-bit instance.
    do_reset();
    for (int i = 0; i < 17; i++) step(1'b1, $urandom, 1'($urandom), 5'($urandom), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 5'd0, 1'b1);
    check_eq("wrap_cnt4", 32'(result_cnt4), 32'd1);
    check_eq("wrap_cnt16", 32'(result_cnt), 32'd17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
